// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_dump_pkg
// Purpose : Shared definitions for the register-dump streamer: register
//           count, index width and the 2-bit state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package reg_dump_pkg;

   // Number of registers in the attached register file.
   localparam int REG_COUNT = 32;

   // Width of a register index / read address.
   localparam int IDX_W = $clog2(REG_COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage : reg_dump_pkg
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
// Module  : reg_dump
// Purpose : Streams registers 0..LAST_IDX of an external register file out
//           over a Valid/Ready interface and accumulates a 32-bit checksum
//           of every accepted word.
// Ports   : Clk    - clock, rising edge
//           Clr    - asynchronous active-high reset
//           Start  - dump request (honoured in IDLE only)
//           Abort  - terminate a dump in progress
//           Ra     - register-file read address (always equals the counter)
//           Qa     - register-file read data, combinational from Ra
//           Dout   - streamed register value
//           Idx    - register index belonging to Dout
//           Valid  - Dout/Idx valid
//           Ready  - consumer accepts the word when Valid & Ready
//           Busy   - high whenever not IDLE
//           Done   - one-cycle pulse at normal completion
//           Sum    - checksum of accepted words
// Rev     : 1.0  initial release
// ============================================================================
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int LAST_IDX = 31
) (
   input  logic              Clk,
   input  logic              Clr,
   input  logic              Start,
   input  logic              Abort,
   output logic [IDX_W-1:0]  Ra,
   input  logic [31:0]       Qa,
   output logic [31:0]       Dout,
   output logic [IDX_W-1:0]  Idx,
   output logic              Valid,
   input  logic              Ready,
   output logic              Busy,
   output logic              Done,
   output logic [31:0]       Sum
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q,   cnt_d;
   logic [31:0]       dout_q,  dout_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [31:0]       sum_q,   sum_d;

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      idx_d   = idx_q;
      sum_d   = sum_q;

      case (state_q)
         IDLE: begin
            // Abort wins over Start; a new dump restarts the index and checksum.
            if (Start && !Abort) begin
               state_d = READ;
               cnt_d   = '0;
               sum_d   = '0;
            end
         end

         READ: begin
            if (Abort) begin
               state_d = IDLE;
            end else begin
               dout_d  = Qa;
               idx_d   = cnt_q;
               state_d = SEND;
            end
         end

         SEND: begin
            if (Ready) begin
               // The handshake completes even if Abort arrives on the same
               // cycle, so the word is folded into the checksum first.
               sum_d = sum_q + dout_q;
               if (Abort) begin
                  state_d = IDLE;
               end else if (idx_q == LAST) begin
                  state_d = DONE;
               end else begin
                  // idx_q < LAST here, so the counter cannot pass LAST.
                  cnt_d   = cnt_q + IDX_W'(1);
                  state_d = READ;
               end
            end else if (Abort) begin
               state_d = IDLE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Ra    = cnt_q;
   assign Dout  = dout_q;
   assign Idx   = idx_q;
   assign Sum   = sum_q;
   assign Valid = (state_q == SEND);
   assign Busy  = (state_q != IDLE);
   assign Done  = (state_q == DONE);

endmodule : reg_dump
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_dump
// Purpose : Directed self-checking bench for reg_dump. Instance A dumps 32
//           registers holding k+0x100; instance B dumps 4 registers holding
//           0xFFFFFFFF to exercise checksum wrap.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_reg_dump;

   logic        clk;
   logic        clr;
   logic        start;
   logic        abort;
   logic        ready;
   logic        sel;

   logic        start_a, start_b, abort_a, abort_b, ready_a, ready_b;
   logic [4:0]  ra_a, ra_b, idx_a, idx_b;
   logic [31:0] qa_a, qa_b, dout_a, dout_b, sum_a, sum_b;
   logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

   logic [4:0]  m_ra, m_idx;
   logic [31:0] m_dout, m_sum;
   logic        m_valid, m_busy, m_done;

   int n_cmp;
   int n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file models.
   assign qa_a = {27'd0, ra_a} + 32'h0000_0100;
   assign qa_b = 32'hFFFF_FFFF;

   assign start_a = start & ~sel;
   assign start_b = start &  sel;
   assign abort_a = abort & ~sel;
   assign abort_b = abort &  sel;
   assign ready_a = ready | sel;
   assign ready_b = ready | ~sel;

   assign m_ra    = sel ? ra_b    : ra_a;
   assign m_idx   = sel ? idx_b   : idx_a;
   assign m_dout  = sel ? dout_b  : dout_a;
   assign m_sum   = sel ? sum_b   : sum_a;
   assign m_valid = sel ? valid_b : valid_a;
   assign m_busy  = sel ? busy_b  : busy_a;
   assign m_done  = sel ? done_b  : done_a;

   reg_dump #(.LAST_IDX(31)) u_dut_a (
      .Clk   (clk),
      .Clr   (clr),
      .Start (start_a),
      .Abort (abort_a),
      .Ra    (ra_a),
      .Qa    (qa_a),
      .Dout  (dout_a),
      .Idx   (idx_a),
      .Valid (valid_a),
      .Ready (ready_a),
      .Busy  (busy_a),
      .Done  (done_a),
      .Sum   (sum_a)
   );

   reg_dump #(.LAST_IDX(3)) u_dut_b (
      .Clk   (clk),
      .Clr   (clr),
      .Start (start_b),
      .Abort (abort_b),
      .Ra    (ra_b),
      .Qa    (qa_b),
      .Dout  (dout_b),
      .Idx   (idx_b),
      .Valid (valid_b),
      .Ready (ready_b),
      .Busy  (busy_b),
      .Done  (done_b),
      .Sum   (sum_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_word(input int k);
      return sel ? 32'hFFFF_FFFF : (32'(k) + 32'h0000_0100);
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ra"},    {27'd0, m_ra},  32'd0);
      chk({tag, "_dout"},  m_dout,         32'd0);
      chk({tag, "_idx"},   {27'd0, m_idx}, 32'd0);
      chk({tag, "_sum"},   m_sum,          32'd0);
      chk({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
      chk({tag, "_busy"},  {31'd0, m_busy},  32'd0);
      chk({tag, "_done"},  {31'd0, m_done},  32'd0);
   endtask

   // Full dump from IDLE. Optionally stalls the first stall_n cycles of word
   // stall_w and raises Start again while word restart_w is presented.
   task automatic run_dump(input int stall_w, input int stall_n, input int restart_w,
                           input logic [31:0] exp_sum, input int n_words);
      int cyc, next_idx, dones, done_cyc, busy_n, stalled;
      logic [31:0] held_sum;
      cyc = 1; next_idx = 0; dones = 0; done_cyc = 0; busy_n = 0; stalled = 0;
      start = 1'b1;
      ready = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < 300) begin
         if (cyc == 1) begin
            chk("lat_c1_valid", {31'd0, m_valid}, 32'd0);
            chk("lat_c1_busy",  {31'd0, m_busy},  32'd1);
         end
         if (cyc == 2) chk("lat_c2_valid", {31'd0, m_valid}, 32'd1);
         if (m_busy) busy_n++;
         if (m_done) begin
            dones++;
            done_cyc = cyc;
         end
         start = (restart_w >= 0) && m_valid && (int'(m_idx) == restart_w);
         if (m_valid) begin
            if ((int'(m_idx) == stall_w) && (stalled < stall_n)) begin
               ready = 1'b0;
               stalled++;
               chk("stall_idx",  {27'd0, m_idx}, 32'(stall_w));
               chk("stall_dout", m_dout, exp_word(stall_w));
            end else begin
               ready = 1'b1;
               chk("word_idx",  {27'd0, m_idx}, 32'(next_idx));
               chk("word_dout", m_dout, exp_word(next_idx));
               next_idx++;
            end
         end else begin
            ready = 1'b1;
         end
         if (!m_busy) break;
         tick();
         cyc++;
      end
      start = 1'b0;
      ready = 1'b1;
      chk("dump_idle",     {31'd0, m_busy}, 32'd0);
      chk("dump_words",    32'(next_idx), 32'(n_words));
      chk("dump_dones",    32'(dones), 32'd1);
      chk("dump_done_cyc", 32'(done_cyc), 32'(2 * n_words + 1 + stall_n));
      chk("dump_busy_cyc", 32'(busy_n),   32'(2 * n_words + 1 + stall_n));
      chk("dump_sum",      m_sum, exp_sum);
      held_sum = m_sum;
      tick();
      tick();
      chk("sum_hold", m_sum, held_sum);
      chk("done_low", {31'd0, m_done}, 32'd0);
   endtask

   // Start a dump and run with Ready high until word w is presented.
   task automatic go_to_word(input int w);
      int budget;
      logic found;
      found = 1'b0;
      start = 1'b1;
      ready = 1'b1;
      tick();
      start = 1'b0;
      for (budget = 0; budget < 200; budget++) begin
         if (m_valid && (int'(m_idx) == w)) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("goto_word_reached", {31'd0, found}, 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      sel   = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      ready = 1'b1;
      clr   = 1'b1;

      // Reset state, both instances.
      #2;
      chk_all_zero("rst_a");
      sel = 1'b1;
      chk_all_zero("rst_b");
      sel = 1'b0;
      tick();
      tick();
      clr = 1'b0;

      // Plain full dump: 32 words, Done at cycle 65, Sum 0x21F0.
      run_dump(-1, 0, -1, 32'h0000_21F0, 32);

      // Ready low for 3 cycles on word 5.
      run_dump(5, 3, -1, 32'h0000_21F0, 32);

      // Second Start while busy at Idx 7 is ignored.
      run_dump(-1, 0, 7, 32'h0000_21F0, 32);

      // Abort during SEND of Idx 10 with Ready low.
      go_to_word(10);
      ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      ready = 1'b1;
      chk("abort_busy",  {31'd0, m_busy},  32'd0);
      chk("abort_valid", {31'd0, m_valid}, 32'd0);
      chk("abort_done",  {31'd0, m_done},  32'd0);
      chk("abort_sum",   m_sum, 32'h0000_0A2D);
      tick();
      chk("abort_done_later", {31'd0, m_done}, 32'd0);
      chk("abort_sum_later",  m_sum, 32'h0000_0A2D);

      // Abort coincident with a handshake on word 4: words 0..4 counted.
      go_to_word(4);
      ready = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_hs_busy", {31'd0, m_busy}, 32'd0);
      chk("abort_hs_sum",  m_sum, 32'h0000_050A);

      // Abort beats Start in IDLE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_prio_busy", {31'd0, m_busy}, 32'd0);
      chk("abort_prio_sum",  m_sum, 32'h0000_050A);

      // Clr mid-dump at Idx 20 clears everything without waiting for an edge.
      go_to_word(20);
      clr = 1'b1;
      #2;
      chk_all_zero("clr_mid");
      tick();
      clr = 1'b0;
      chk_all_zero("clr_held");
      run_dump(-1, 0, -1, 32'h0000_21F0, 32);

      // LAST_IDX=3 instance with all-ones registers: checksum wraps.
      sel = 1'b1;
      run_dump(-1, 0, -1, 32'hFFFF_FFFC, 4);
      sel = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_reg_dump
`default_nettype wire
